// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding, error codes and ack bytes for the UART command parser
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_BREAK   = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  localparam logic [7:0] ACK_BYTE   = 8'h06;
  localparam logic [4:0] NAK_PREFIX = 5'b10101;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload buffer, one write port and one registered read port
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store payload bytes as they arrive; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read so the next write's data is ready one cycle ahead.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART command frame parser and register-write replayer (ack port behind UART_CMD_ACK_EN)
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_break,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
`ifdef UART_CMD_ACK_EN
  ,
  output logic       ack_valid,
  output logic [7:0] ack_data,
  input  logic       ack_ready
`endif
);

  localparam int IW  = $clog2(MAX_LEN + 1);
  localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          state_next;
  logic [7:0]      base_q;
  logic [7:0]      chk_q;
  logic [IW-1:0]   len_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_inc;
  logic [TW-1:0]   tmo_q;
  logic            ovr_q;
  logic            frame_err_q;
  logic [2:0]      err_code_q;
  logic            err_fire;
  logic [2:0]      err_val;
  logic            byte_ok;
  logic            last_wr;
  logic            buf_we;
  logic [BAW-1:0]  buf_raddr;
  logic [7:0]      buf_rdata;

  assign byte_ok = rx_valid && !rx_break;
  assign idx_inc = idx_q + IW'(1);
  assign last_wr = (state == ST_COMMIT) && (idx_inc == len_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame decoding: next state plus any error raised this cycle.
  always_comb begin
    state_next = state;
    err_fire   = 1'b0;
    err_val    = err_code_q;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_break) begin
          err_fire = 1'b1;
          err_val  = ERR_BREAK;
        end else if (byte_ok && (rx_data == SYNC_BYTE)) begin
          state_next = ST_ADDR;
        end
      end
      ST_ADDR, ST_LEN, ST_DATA, ST_CHK: begin
        if (rx_valid && rx_break) begin
          err_fire   = 1'b1;
          err_val    = ERR_BREAK;
          state_next = ST_IDLE;
        end else if (rx_valid) begin
          if (state == ST_ADDR) begin
            state_next = ST_LEN;
          end else if (state == ST_LEN) begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              err_fire   = 1'b1;
              err_val    = ERR_LEN;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DATA;
            end
          end else if (state == ST_DATA) begin
            if (idx_inc == len_q) begin
              state_next = ST_CHK;
            end
          end else begin
            if (rx_data == chk_q) begin
              state_next = ST_COMMIT;
            end else begin
              err_fire   = 1'b1;
              err_val    = ERR_CHK;
              state_next = ST_IDLE;
            end
          end
        end else if (tmo_q >= TMO_LAST) begin
          err_fire   = 1'b1;
          err_val    = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        // Bytes arriving mid-commit are lost; report once the commit has finished.
        if (last_wr) begin
          state_next = ST_IDLE;
          if (ovr_q || rx_valid) begin
            err_fire = 1'b1;
            err_val  = ERR_OVERRUN;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: address, length, running checksum, index, inter-byte timer, error reporting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_q      <= '0;
      chk_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      ovr_q       <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      frame_err_q <= err_fire;
      if (err_fire) begin
        err_code_q <= err_val;
      end
      // tmo_q counts cycles since the last byte, so it reads TIMEOUT_CYC when the error shows.
      if (rx_valid) begin
        tmo_q <= TW'(1);
      end else if (state inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK}) begin
        tmo_q <= tmo_q + TW'(1);
      end else begin
        tmo_q <= '0;
      end
      case (state)
        ST_IDLE: ovr_q <= 1'b0;
        ST_ADDR: begin
          if (byte_ok) begin
            base_q <= rx_data;
            chk_q  <= rx_data;
          end
        end
        ST_LEN: begin
          if (byte_ok) begin
            len_q <= rx_data[IW-1:0];
            chk_q <= chk_q ^ rx_data;
            idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (byte_ok) begin
            chk_q <= chk_q ^ rx_data;
            idx_q <= (idx_inc == len_q) ? '0 : idx_inc;
          end
        end
        ST_COMMIT: begin
          idx_q <= idx_inc;
          if (rx_valid) begin
            ovr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // During CHK the read port prefetches entry 0; during COMMIT it runs one entry ahead.
  assign buf_we    = (state == ST_DATA) && byte_ok;
  assign buf_raddr = (state == ST_COMMIT) ? idx_inc[BAW-1:0] : '0;

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BAW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[BAW-1:0]),
    .wdata (rx_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  assign wr_en     = (state == ST_COMMIT);
  assign wr_addr   = wr_en ? (base_q + 8'(idx_q)) : 8'h00;
  assign wr_data   = wr_en ? buf_rdata : 8'h00;
  assign busy      = (state != ST_IDLE);
  assign frame_ok  = last_wr;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

`ifdef UART_CMD_ACK_EN
  // Latest frame outcome becomes the pending ack byte, held until accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_valid <= 1'b0;
      ack_data  <= 8'h00;
    end else if (frame_ok) begin
      ack_valid <= 1'b1;
      ack_data  <= ACK_BYTE;
    end else if (frame_err_q) begin
      ack_valid <= 1'b1;
      ack_data  <= {NAK_PREFIX, err_code_q};
    end else if (ack_ready) begin
      ack_valid <= 1'b0;
    end
  end
`endif

endmodule
